// File: rtl/ex_mem_queue.sv
// rtl/ex_mem_queue.sv - EX to MEM bundle FIFO with lane kill on capture and flush
// Holds up to DEPTH issue bundles; lanes younger than the oldest excepting lane are dropped at capture.
module ex_mem_queue #(
   parameter  int LANES     = 2,
   parameter  int PAYLOAD_W = 160,
   parameter  int EXC_W     = 2,
   parameter  int DEPTH     = 2,
   localparam int CNT_W     = $clog2(DEPTH + 1),
   localparam int PTR_W     = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
   input  logic                       clk,
   input  logic                       rst,
   input  logic                       flush,
   input  logic [LANES-1:0]           in_valid,
   input  logic [LANES*PAYLOAD_W-1:0] in_payload,
   input  logic [LANES*EXC_W-1:0]     in_excp,
   output logic                       in_ready,
   output logic [LANES-1:0]           out_valid,
   output logic [LANES*PAYLOAD_W-1:0] out_payload,
   output logic [LANES*EXC_W-1:0]     out_excp,
   input  logic                       out_ready,
   output logic [CNT_W-1:0]           out_count
);

   logic [LANES-1:0]           mask_q    [DEPTH];
   logic [LANES-1:0]           mask_d    [DEPTH];
   logic [LANES*PAYLOAD_W-1:0] payload_q [DEPTH];
   logic [LANES*PAYLOAD_W-1:0] payload_d [DEPTH];
   logic [LANES*EXC_W-1:0]     excp_q    [DEPTH];
   logic [LANES*EXC_W-1:0]     excp_d    [DEPTH];

   logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
   logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
   logic [CNT_W-1:0] count_q, count_d;

   logic                       push;
   logic                       pop;
   logic                       killed;
   logic [LANES-1:0]           cap_mask;
   logic [LANES*PAYLOAD_W-1:0] cap_payload;
   logic [LANES*EXC_W-1:0]     cap_excp;

   function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
      return (p == PTR_W'(DEPTH - 1)) ? '0 : p + PTR_W'(1);
   endfunction

   assign in_ready = (count_q < CNT_W'(DEPTH));
   assign push     = in_ready & (|in_valid) & ~flush;
   assign pop      = (count_q != '0) & out_ready & ~flush;

   // Walk lanes oldest first; the first excepting lane is kept, everything after it is dropped.
   always_comb begin
      killed      = 1'b0;
      cap_mask    = '0;
      cap_payload = '0;
      cap_excp    = '0;
      for (int i = 0; i < LANES; i++) begin
         if (in_valid[i] && !killed) begin
            cap_mask[i]                          = 1'b1;
            cap_payload[i*PAYLOAD_W +: PAYLOAD_W] = in_payload[i*PAYLOAD_W +: PAYLOAD_W];
            cap_excp[i*EXC_W +: EXC_W]           = in_excp[i*EXC_W +: EXC_W];
            if (in_excp[i*EXC_W +: EXC_W] != '0) begin
               killed = 1'b1;
            end
         end
      end
   end

   always_comb begin
      mask_d    = mask_q;
      payload_d = payload_q;
      excp_d    = excp_q;
      rd_ptr_d  = rd_ptr_q;
      wr_ptr_d  = wr_ptr_q;
      count_d   = count_q;
      if (flush) begin
         rd_ptr_d = '0;
         wr_ptr_d = '0;
         count_d  = '0;
      end else begin
         if (push) begin
            mask_d[wr_ptr_q]    = cap_mask;
            payload_d[wr_ptr_q] = cap_payload;
            excp_d[wr_ptr_q]    = cap_excp;
            wr_ptr_d            = ptr_inc(wr_ptr_q);
         end
         if (pop) begin
            rd_ptr_d = ptr_inc(rd_ptr_q);
         end
         if (push && !pop) begin
            count_d = count_q + CNT_W'(1);
         end else if (pop && !push) begin
            count_d = count_q - CNT_W'(1);
         end
      end
   end

   always_ff @(posedge clk) begin
      if (!rst) begin
         rd_ptr_q <= '0;
         wr_ptr_q <= '0;
         count_q  <= '0;
      end else begin
         rd_ptr_q <= rd_ptr_d;
         wr_ptr_q <= wr_ptr_d;
         count_q  <= count_d;
      end
   end

   // Entry storage is never cleared; the count gates what the outputs can see.
   always_ff @(posedge clk) begin
      mask_q    <= mask_d;
      payload_q <= payload_d;
      excp_q    <= excp_d;
   end

   assign out_valid   = (count_q != '0) ? mask_q[rd_ptr_q]    : '0;
   assign out_payload = (count_q != '0) ? payload_q[rd_ptr_q] : '0;
   assign out_excp    = (count_q != '0) ? excp_q[rd_ptr_q]    : '0;
   assign out_count   = count_q;

endmodule

// File: tb/tb_ex_mem_queue.sv
// tb/tb_ex_mem_queue.sv - self-checking bench for ex_mem_queue against a queue-based reference model
module tb_ex_mem_queue;

   localparam int LANES = 2;
   localparam int PW    = 160;
   localparam int EW    = 2;
   localparam int DEPTH = 3;
   localparam int CW    = $clog2(DEPTH + 1);

   logic                  clk = 1'b0;
   logic                  rst;
   logic                  flush;
   logic [LANES-1:0]      in_valid;
   logic [LANES*PW-1:0]   in_payload;
   logic [LANES*EW-1:0]   in_excp;
   logic                  in_ready;
   logic [LANES-1:0]      out_valid;
   logic [LANES*PW-1:0]   out_payload;
   logic [LANES*EW-1:0]   out_excp;
   logic                  out_ready;
   logic [CW-1:0]         out_count;

   int checks = 0;
   int errors = 0;

   typedef struct {
      logic [LANES-1:0]    m;
      logic [LANES*PW-1:0] p;
      logic [LANES*EW-1:0] e;
   } bundle_t;

   bundle_t mq[$];

   typedef struct {
      logic [1:0] v;
      logic [3:0] e;
      logic [1:0] xv;
      logic [3:0] xe;
      int         xcount;
   } kill_vec_t;

   kill_vec_t tbl[7];

   ex_mem_queue #(.LANES(LANES), .PAYLOAD_W(PW), .EXC_W(EW), .DEPTH(DEPTH)) dut (
      .clk         (clk),
      .rst         (rst),
      .flush       (flush),
      .in_valid    (in_valid),
      .in_payload  (in_payload),
      .in_excp     (in_excp),
      .in_ready    (in_ready),
      .out_valid   (out_valid),
      .out_payload (out_payload),
      .out_excp    (out_excp),
      .out_ready   (out_ready),
      .out_count   (out_count)
   );

   always #5 clk = ~clk;

   task automatic chk(input string nm, input logic [511:0] act, input logic [511:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", nm, act, exp);
      end
   endtask

   function automatic logic [LANES*PW-1:0] rand_payload();
      logic [LANES*PW-1:0] r;
      for (int i = 0; i < LANES * PW / 32; i++) r[i*32 +: 32] = $urandom;
      return r;
   endfunction

   // Model of capture: find the oldest excepting valid lane, keep it and all older valid lanes.
   function automatic bundle_t capture(input logic [LANES-1:0] v, input logic [LANES*PW-1:0] p,
                                       input logic [LANES*EW-1:0] e);
      bundle_t b;
      int k = LANES;
      for (int i = LANES - 1; i >= 0; i--)
         if (v[i] && e[i*EW +: EW] != 0) k = i;
      b.m = '0; b.p = '0; b.e = '0;
      for (int i = 0; i < LANES; i++) begin
         if (v[i] && i <= k) begin
            b.m[i]           = 1'b1;
            b.p[i*PW +: PW]  = p[i*PW +: PW];
            b.e[i*EW +: EW]  = e[i*EW +: EW];
         end
      end
      return b;
   endfunction

   task automatic step();
      bit pm, qm;
      bundle_t b;
      pm = (mq.size() < DEPTH) && (|in_valid) && !flush;
      qm = (mq.size() != 0) && out_ready && !flush;
      b  = capture(in_valid, in_payload, in_excp);
      @(posedge clk);
      if (!rst || flush) begin
         mq.delete();
      end else begin
         if (qm) void'(mq.pop_front());
         if (pm) mq.push_back(b);
      end
      #1;
      chk("model_in_ready", in_ready, mq.size() < DEPTH);
      chk("model_count", out_count, mq.size());
      if (mq.size() != 0) begin
         chk("model_out_valid", out_valid, mq[0].m);
         chk("model_out_payload", out_payload, mq[0].p);
         chk("model_out_excp", out_excp, mq[0].e);
      end else begin
         chk("model_out_valid", out_valid, 0);
         chk("model_out_payload", out_payload, 0);
         chk("model_out_excp", out_excp, 0);
      end
   endtask

   task automatic set_bundle(input logic [1:0] v, input logic [31:0] pc, input logic [3:0] e);
      in_valid             = v;
      in_payload           = rand_payload();
      in_payload[31:0]     = pc;
      in_payload[PW +: 32] = pc + 32'd4;
      in_excp              = e;
   endtask

   task automatic idle_inputs();
      in_valid   = '0;
      in_payload = '0;
      in_excp    = '0;
   endtask

   initial begin
      logic [LANES*PW-1:0] pv;
      logic [LANES*PW-1:0] xp;

      rst = 1'b0; flush = 1'b0; out_ready = 1'b0;
      set_bundle(2'b11, 32'h40, 4'b0000);
      step();
      step();
      rst = 1'b1;
      idle_inputs();
      chk("reset_out_valid", out_valid, 0);
      chk("reset_out_payload", out_payload, 0);
      chk("reset_out_count", out_count, 0);
      chk("reset_in_ready", in_ready, 1);

      // Streaming: one bundle per cycle with out_ready held high
      out_ready = 1'b1;
      for (int i = 0; i < 3; i++) begin
         set_bundle(2'b11, 32'h100 + 32'(i * 8), 4'b0000);
         step();
         chk("stream_head_pc", out_payload[31:0], 32'h100 + 32'(i * 8));
         chk("stream_count", out_count, 1);
         chk("stream_in_ready", in_ready, 1);
      end
      idle_inputs();
      step();
      chk("stream_drained", out_count, 0);

      // Backpressure: fill to DEPTH, fourth push refused
      flush = 1'b1; step(); flush = 1'b0;
      out_ready = 1'b0;
      for (int i = 0; i < 4; i++) begin
         set_bundle(2'b11, 32'h200 + 32'(i * 8), 4'b0000);
         step();
      end
      chk("bp_count_full", out_count, 3);
      chk("bp_in_ready_low", in_ready, 0);
      chk("bp_head", out_payload[31:0], 32'h200);
      out_ready = 1'b1;
      step();
      chk("bp_refused_while_popping", out_count, 2);
      chk("bp_in_ready_back", in_ready, 1);
      chk("bp_head_after_pop", out_payload[31:0], 32'h208);
      set_bundle(2'b11, 32'h218, 4'b0000);
      step();
      idle_inputs();
      chk("wrap_head", out_payload[31:0], 32'h210);
      step();
      chk("wrap_head_after", out_payload[31:0], 32'h218);
      step();
      chk("wrap_empty", out_count, 0);

      // Flush with simultaneous push and pop
      out_ready = 1'b0;
      set_bundle(2'b11, 32'h280, 4'b0000); step();
      set_bundle(2'b11, 32'h288, 4'b0000); step();
      chk("flush_pre_count", out_count, 2);
      flush = 1'b1; out_ready = 1'b1;
      set_bundle(2'b11, 32'h290, 4'b0000);
      step();
      flush = 1'b0;
      chk("flush_count", out_count, 0);
      chk("flush_out_valid", out_valid, 0);
      out_ready = 1'b0;
      set_bundle(2'b11, 32'h300, 4'b0000);
      step();
      chk("post_flush_head", out_payload[31:0], 32'h300);
      chk("post_flush_count", out_count, 1);

      // Push and pop together at count 1
      out_ready = 1'b1;
      set_bundle(2'b11, 32'h308, 4'b0000);
      step();
      chk("pp_count", out_count, 1);
      chk("pp_head", out_payload[31:0], 32'h308);
      idle_inputs();
      step();
      chk("pp_drained", out_count, 0);

      // Lane kill table
      tbl[0] = '{2'b11, 4'b0001, 2'b01, 4'b0001, 1};
      tbl[1] = '{2'b11, 4'b1000, 2'b11, 4'b1000, 1};
      tbl[2] = '{2'b11, 4'b1111, 2'b01, 4'b0011, 1};
      tbl[3] = '{2'b10, 4'b1101, 2'b10, 4'b1100, 1};
      tbl[4] = '{2'b01, 4'b1100, 2'b01, 4'b0000, 1};
      tbl[5] = '{2'b00, 4'b1111, 2'b00, 4'b0000, 0};
      tbl[6] = '{2'b11, 4'b0000, 2'b11, 4'b0000, 1};
      for (int t = 0; t < 7; t++) begin
         idle_inputs();
         flush = 1'b1; step(); flush = 1'b0;
         out_ready = 1'b0;
         pv = rand_payload();
         in_valid = tbl[t].v; in_payload = pv; in_excp = tbl[t].e;
         step();
         xp = '0;
         for (int l = 0; l < LANES; l++)
            if (tbl[t].xv[l]) xp[l*PW +: PW] = pv[l*PW +: PW];
         chk($sformatf("kill%0d_valid", t), out_valid, tbl[t].xv);
         chk($sformatf("kill%0d_excp", t), out_excp, tbl[t].xe);
         chk($sformatf("kill%0d_payload", t), out_payload, xp);
         chk($sformatf("kill%0d_count", t), out_count, tbl[t].xcount);
      end

      // Random traffic against the model
      for (int c = 0; c < 2000; c++) begin
         rst       = ($urandom_range(0, 99) != 0);
         flush     = ($urandom_range(0, 15) == 0);
         out_ready = $urandom_range(0, 1);
         in_valid  = $urandom_range(0, 3);
         in_payload = rand_payload();
         for (int l = 0; l < LANES; l++)
            in_excp[l*EW +: EW] = ($urandom_range(0, 3) == 0) ? EW'($urandom_range(1, 3)) : '0;
         step();
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
